// File: rtl/lifo.sv
// rtl/lifo.sv - Parameterised LIFO stack with registered pop data and count-decoded full/empty.
// Define LIFO_ERR_FLAGS_EN to add registered overflow/underflow pulse outputs.
module lifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
`ifdef LIFO_ERR_FLAGS_EN
  ,
  output logic             overflow,
  output logic             underflow
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [CW-1:0]    top_cnt;
  logic [AW-1:0]    top_addr;
  logic [AW-1:0]    cnt_addr;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = dout_q;

  // top_addr is only meaningful when not empty; cnt_addr only when not full.
  assign top_cnt  = count_q - CW'(1);
  assign top_addr = top_cnt[AW-1:0];
  assign cnt_addr = count_q[AW-1:0];

  always_comb begin
    count_d = count_q;
    dout_d  = dout_q;
    wr_en   = 1'b0;
    wr_addr = cnt_addr;
    case ({push, pop})
      2'b10: begin
        if (!full) begin
          wr_en   = 1'b1;
          wr_addr = cnt_addr;
          count_d = count_q + CW'(1);
        end
      end
      2'b01: begin
        if (!empty) begin
          dout_d  = mem_q[top_addr];
          count_d = top_cnt;
        end
      end
      2'b11: begin
        // Simultaneous push/pop swaps the top entry; on an empty stack only the push lands.
        if (empty) begin
          wr_en   = 1'b1;
          wr_addr = '0;
          count_d = CW'(1);
        end else begin
          dout_d  = mem_q[top_addr];
          wr_en   = 1'b1;
          wr_addr = top_addr;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      dout_q  <= '0;
    end else begin
      count_q <= count_d;
      dout_q  <= dout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= din;
    end
  end

`ifdef LIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  assign overflow_d  = push & ~pop & full;
  assign underflow_d = pop & ~push & empty;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end
`endif

endmodule

// File: tb/tb_lifo.sv
// tb/tb_lifo.sv - Scoreboard bench for lifo: queue-based stack model, directed and random stimulus.
module tb_lifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk;
  logic             reset;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             full;
  logic             empty;
`ifdef LIFO_ERR_FLAGS_EN
  logic             overflow;
  logic             underflow;
`endif

  lifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (dout),
    .full  (full),
`ifdef LIFO_ERR_FLAGS_EN
    .overflow  (overflow),
    .underflow (underflow),
`endif
    .empty (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int               id;
    logic [WIDTH-1:0] dout;
    logic             full;
    logic             empty;
    logic             ov;
    logic             un;
  } exp_t;

  exp_t             exp_q[$];
  logic [WIDTH-1:0] stk[$];
  logic [WIDTH-1:0] mdout;
  int               checks = 0;
  int               errors = 0;
  int               step_id = 0;

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step=%0d actual=%0h expected=%0h", nm, id, act, exp);
    end
  endtask

  // Reference: stack kept as a queue, top at the back.
  task automatic step(input logic p, input logic q, input logic [WIDTH-1:0] d);
    exp_t e;
    logic ov, un;
    @(negedge clk);
    push = p; pop = q; din = d;
    @(posedge clk);
    ov = p && !q && (stk.size() == DEPTH);
    un = q && !p && (stk.size() == 0);
    if (p && q) begin
      if (stk.size() == 0) stk.push_back(d);
      else begin
        mdout = stk[stk.size()-1];
        stk[stk.size()-1] = d;
      end
    end else if (p) begin
      if (stk.size() < DEPTH) stk.push_back(d);
    end else if (q) begin
      if (stk.size() > 0) mdout = stk.pop_back();
    end
    e.id    = step_id;
    e.dout  = mdout;
    e.full  = (stk.size() == DEPTH);
    e.empty = (stk.size() == 0);
    e.ov    = ov;
    e.un    = un;
    exp_q.push_back(e);
    step_id++;
  endtask

  task automatic check_reset_outputs(input int id);
    chk("rst_dout", id, 32'(dout), 32'h0);
    chk("rst_empty", id, 32'(empty), 32'h1);
    chk("rst_full", id, 32'(full), 32'h0);
`ifdef LIFO_ERR_FLAGS_EN
    chk("rst_overflow", id, 32'(overflow), 32'h0);
    chk("rst_underflow", id, 32'(underflow), 32'h0);
`endif
  endtask

  task automatic async_reset();
    @(negedge clk);
    push = 1'b0; pop = 1'b0;
    #2 reset = 1'b1;
    #1 check_reset_outputs(step_id);
    stk.delete();
    mdout = '0;
    #1 reset = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("dout", e.id, 32'(dout), 32'(e.dout));
        chk("full", e.id, 32'(full), 32'(e.full));
        chk("empty", e.id, 32'(empty), 32'(e.empty));
`ifdef LIFO_ERR_FLAGS_EN
        chk("overflow", e.id, 32'(overflow), 32'(e.ov));
        chk("underflow", e.id, 32'(underflow), 32'(e.un));
`endif
      end
    end
  end

  initial begin : stimulus
    int wait_cnt;
    reset = 1'b1; push = 1'b0; pop = 1'b0; din = '0;
    mdout = '0;
    #3 check_reset_outputs(-1);
    repeat (2) @(posedge clk);
    #1 check_reset_outputs(-1);
    @(negedge clk);
    reset = 1'b0;

    // Fill to full, then drain in reverse order plus one extra pop.
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 8'(i));
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h00);

    // Overfill: the fifth push is dropped.
    for (int i = 5; i <= 9; i++) step(1'b1, 1'b0, 8'(i));
    step(1'b0, 1'b1, 8'h00);

    // Three entries stored: async reset, then pop on empty.
    async_reset();
    step(1'b0, 1'b1, 8'h00);

    // Swap on a non-empty stack.
    step(1'b1, 1'b0, 8'hAA);
    step(1'b1, 1'b0, 8'hBB);
    step(1'b1, 1'b1, 8'hCC);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h00);

    // Push+pop while empty acts as a push only.
    step(1'b1, 1'b1, 8'h5A);
    step(1'b0, 1'b1, 8'h00);

    // Swap while full.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'h10 + i));
    step(1'b1, 1'b1, 8'hEE);

    for (int i = 0; i < 400; i++) begin
      logic p, q;
      p = ($urandom_range(0, 99) < 50);
      q = ($urandom_range(0, 99) < 45);
      step(p, q, 8'($urandom));
      if ($urandom_range(0, 99) == 0) async_reset();
    end
    @(negedge clk);
    push = 1'b0; pop = 1'b0;

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(negedge clk);
      wait_cnt++;
    end
    #1;
    chk("drain_timeout", step_id, 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lifo.md
LIFO -- requirements
Module: lifo

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter DEPTH, default 4, number of stored entries; legal range is 2 or more.
REQ-003 Port clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1, asynchronous active-high reset.
REQ-005 Port push, input, 1, write request for din.
REQ-006 Port pop, input, 1, read request for the top entry.
REQ-007 Port din, input, WIDTH, data to push.
REQ-008 Port dout, output, WIDTH, registered value of the most recently popped entry.
REQ-009 Port full, output, 1, high when count equals DEPTH.
REQ-010 Port empty, output, 1, high when count equals 0.

Function
REQ-011 The block SHALL keep an internal occupancy count in the range 0..DEPTH, with width $clog2(DEPTH+1).
REQ-012 full and empty SHALL be combinational decodes of count only.
REQ-013 A push accepted while not full (push=1, pop=0) SHALL write din to slot[count] and increment count at the same edge.
REQ-014 A push while full with pop=0 SHALL be dropped: count, storage and dout unchanged.
REQ-015 A pop accepted while not empty (pop=1, push=0) SHALL load dout with slot[count-1] and decrement count at the same edge, giving one-cycle latency.
REQ-016 A pop while empty with push=0 SHALL be ignored: dout holds its value and count stays 0.
REQ-017 If push=1 and pop=1 while not empty (full included), the block SHALL load dout with slot[count-1], overwrite slot[count-1] with din, and leave count unchanged.
REQ-018 If push=1 and pop=1 while empty, only the push SHALL take effect: slot[0] gets din, count becomes 1, and dout holds.
REQ-019 dout SHALL hold its value on every cycle without an accepted pop.
REQ-020 Storage contents need not be reset; no slot at or above count SHALL ever be visible on dout.

Reset
REQ-021 While reset=1, regardless of clk: count SHALL be 0, dout SHALL be 0, empty SHALL be 1, and full SHALL be 0.
REQ-022 Asserting reset mid-operation SHALL discard all stored entries; the first edge after release SHALL behave as for an empty stack.

Configuration
REQ-023 With macro LIFO_ERR_FLAGS_EN defined, the block SHALL add outputs overflow (1 bit) and underflow (1 bit), both registered and reset to 0.
REQ-024 With LIFO_ERR_FLAGS_EN defined, overflow SHALL pulse high for one cycle after an edge where a push was dropped per REQ-014.
REQ-025 With LIFO_ERR_FLAGS_EN defined, underflow SHALL pulse high for one cycle after an edge where a pop was ignored per REQ-016.
REQ-026 Without LIFO_ERR_FLAGS_EN, these two ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-027 Reset, then push 01,02,03,04 on consecutive cycles -> full=1 and empty=0 after the 4th edge; dout stays 00.
REQ-028 From that state, pop for 4 cycles -> dout reads 04,03,02,01 on successive edges; empty=1 afterwards; a 5th pop leaves dout=01.
REQ-029 From empty, push 05,06,07,08,09 then pop once -> 09 is dropped (overflow pulse when LIFO_ERR_FLAGS_EN is defined), full=1 before the pop, and the pop gives dout=08 with full=0.
REQ-030 With 2 entries (AA, BB), assert push=1 and pop=1 with din=CC -> dout=BB, count stays 2, and the next pop gives dout=CC.
REQ-031 With 3 entries stored, assert reset asynchronously between edges -> immediately dout=00, empty=1, full=0; after release, a pop leaves dout at 00.
REQ-032 Assert push=1 and pop=1 while empty with din=5A -> empty=0 and dout holds; the next pop gives dout=5A.
